fifo_sync_flags: RTL and testbench
==================================

// Module: fifo_sync_flags
// PURPOSE
//  Single-clock FIFO, successor to the basic push/pop FIFO. Adds an occupancy count,
//  programmable almost-full/almost-empty flags, sticky overflow/underflow errors,
//  and a selectable read mode: registered read, or first-word-fall-through (FWFT).
//  Buffers bursts between producer/consumer blocks in the same clock domain (UART, display paths).
// PARAMETERS
//  WIDTH     8  data width in bits
//  DEPTH     4  entries; power of two, >= 2
//  AF_LEVEL  3  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  1  almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//  FWFT      0  0 = registered read; 1 = head word presented on pop_data while !empty
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  rst_n        in   1              synchronous active-low reset
//  push_en      in   1              write request
//  push_data    in   WIDTH          write data
//  pop_en       in   1              read request
//  pop_data     out  WIDTH          read data
//  full         out  1              count == DEPTH
//  empty        out  1              count == 0
//  almost_full  out  1              count >= AF_LEVEL
//  almost_empty out  1              count <= AE_LEVEL
//  count        out  $clog2(DEPTH+1) current occupancy
//  overflow     out  1              sticky: push rejected
//  underflow    out  1              sticky: pop rejected
//  clear_err    in   1              clears overflow/underflow
// BEHAVIOUR
//  Reset (rst_n low at edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1,
//   almost_full=0, overflow=underflow=0, pop_data=0. Memory contents not reset. Reset mid-burst
//   discards all data; in-flight push/pop that cycle are ignored.
//  pop_ok  = pop_en && !empty.
//  push_ok = push_en && (!full || pop_ok)   -- push into full FIFO allowed when a pop frees a slot.
//  push_ok: mem[wr_ptr] <= push_data, wr_ptr += 1. pop_ok: rd_ptr += 1.
//  Pointers are log2(DEPTH) bits, wrap modulo DEPTH naturally.
//  count' = count + push_ok - pop_ok; both => count unchanged. All flags derived
//   from registered count; they update on the same edge as count.
//  push_en && !push_ok => overflow <= 1. pop_en && empty => underflow <= 1 (a simultaneous
//   push into an empty FIFO is still accepted). Flags hold until clear_err or reset;
//   clear_err loses to a new error in the same cycle (error wins).
//  FWFT=0: on pop_ok, pop_data <= mem[rd_ptr] (valid the cycle after the pop edge);
//   otherwise pop_data holds its last value.
//  FWFT=1: pop_data = mem[rd_ptr] combinationally; valid whenever !empty; pop_en acknowledges
//   the presented word. Word pushed into empty FIFO is visible the cycle after its push edge.
//   Value while empty is don't-care.
//  No state machine; pure pointer/counter datapath. Inferable as iCE40 BRAM in FWFT=0.
// TESTING (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, both FWFT values)
//  1 Reset: after rst_n low one edge -> empty=1, full=0, count=0, errors=0, pop_data=0.
//  2 Push 1..7 on consecutive cycles, no pop -> count 1,2,3,4; almost_full at count 3;
//    full at 4; pushes of 5,6,7 rejected, overflow=1 and stays 1.
//  3 Then pop 4 times -> data 1,2,3,4 in order (FWFT=0: one cycle after each pop; FWFT=1:
//    present before each pop); empty=1 after 4th; 5th pop -> underflow=1, count stays 0.
//  4 Full FIFO with push_en&&pop_en same cycle -> count stays 4, no overflow, data order kept.
//  5 Push/pop interleaved for 10 words -> wrap-around, output sequence equals input sequence.
//  6 clear_err pulse -> both errors 0; clear_err with simultaneous rejected push -> overflow=1;
//    rst_n low mid-burst -> count=0, empty=1 next cycle.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// sticky overflow/underflow errors and a registered or fall-through read port.
module fifo_sync_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1,
    parameter bit FWFT     = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_en,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop_en,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = pop_en && !w_empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_push_ok = push_en && (!w_full || w_pop_ok);

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage is left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push_en && !w_push_ok) begin
                r_overflow <= 1'b1;
            end else if (clear_err) begin
                r_overflow <= 1'b0;
            end
            if (pop_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clear_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign pop_data = r_mem[r_rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] r_pop_data;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pop_data <= '0;
                end else if (w_pop_ok) begin
                    r_pop_data <= r_mem[r_rd_ptr];
                end
            end
            assign pop_data = r_pop_data;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Scoreboard bench: one stimulus stream drives a registered-read and a
// fall-through instance; per-instance monitors check popped data in order.
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push_en;
    logic [7:0] push_data;
    logic       pop_en;
    logic       clear_err;

    logic [7:0] pd0, pd1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [2:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    int         m_cnt;
    bit         m_ovf, m_udf;
    logic [7:0] m_q[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    always #5 clk = ~clk;

    fifo_sync_flags #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3),
                      .AE_LEVEL(1), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .push_en(push_en), .push_data(push_data),
        .pop_en(pop_en), .pop_data(pd0),
        .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ovf0), .underflow(udf0),
        .clear_err(clear_err)
    );

    fifo_sync_flags #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3),
                      .AE_LEVEL(1), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .push_en(push_en), .push_data(push_data),
        .pop_en(pop_en), .pop_data(pd1),
        .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1), .underflow(udf1),
        .clear_err(clear_err)
    );

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic check_flags();
        chk("count0", 32'(cnt0), 32'(m_cnt));
        chk("count1", 32'(cnt1), 32'(m_cnt));
        chk("full0", 32'(full0), 32'(m_cnt == 4));
        chk("full1", 32'(full1), 32'(m_cnt == 4));
        chk("empty0", 32'(empty0), 32'(m_cnt == 0));
        chk("empty1", 32'(empty1), 32'(m_cnt == 0));
        chk("afull0", 32'(af0), 32'(m_cnt >= 3));
        chk("afull1", 32'(af1), 32'(m_cnt >= 3));
        chk("aempty0", 32'(ae0), 32'(m_cnt <= 1));
        chk("aempty1", 32'(ae1), 32'(m_cnt <= 1));
        chk("ovf0", 32'(ovf0), 32'(m_ovf));
        chk("ovf1", 32'(ovf1), 32'(m_ovf));
        chk("udf0", 32'(udf0), 32'(m_udf));
        chk("udf1", 32'(udf1), 32'(m_udf));
    endtask

    // Check the state left by the previous edge, then drive the next cycle.
    task automatic step(input bit rst, input bit push, input int d,
                        input bit pop, input bit clr);
        bit pop_ok, push_ok;
        @(negedge clk);
        check_flags();
        rst_n     = rst;
        push_en   = push;
        push_data = 8'(d);
        pop_en    = pop;
        clear_err = clr;
        if (!rst) begin
            m_cnt = 0;
            m_ovf = 0;
            m_udf = 0;
            m_q.delete();
        end else begin
            pop_ok  = pop && (m_cnt > 0);
            push_ok = push && ((m_cnt < 4) || pop_ok);
            if (pop_ok) begin
                exp0.push_back(m_q[0]);
                exp1.push_back(m_q[0]);
                void'(m_q.pop_front());
                m_cnt--;
            end
            if (push_ok) begin
                m_q.push_back(8'(d));
                m_cnt++;
            end
            if (push && !push_ok) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (pop && !pop_ok) m_udf = 1;
            else if (clr) m_udf = 0;
        end
    endtask

    // Registered read: word appears just after the accepting edge.
    always @(posedge clk) begin
        bit fire;
        fire = rst_n && pop_en && !empty0;
        #1;
        if (fire) begin
            if (exp0.size() == 0) begin
                chk("rd0_unexpected", 32'(pd0), 32'hFFFF_FFFF);
            end else begin
                chk("rd0_data", 32'(pd0), 32'(exp0.pop_front()));
            end
        end
    end

    // Fall-through: word must already be presented when pop is accepted.
    always @(posedge clk) begin
        bit fire;
        logic [7:0] v;
        fire = rst_n && pop_en && !empty1;
        v = pd1;
        if (fire) begin
            #1;
            if (exp1.size() == 0) begin
                chk("rd1_unexpected", 32'(v), 32'hFFFF_FFFF);
            end else begin
                chk("rd1_data", 32'(v), 32'(exp1.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        push_en = 1'b0;
        push_data = 8'h00;
        pop_en = 1'b0;
        clear_err = 1'b0;
        m_cnt = 0;
        m_ovf = 0;
        m_udf = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pop_data0", 32'(pd0), 32'h0);
        // reset state, then fill past full
        for (int v = 1; v <= 7; v++) step(1, 1, v, 0, 0);
        // drain and underflow once
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        // full with simultaneous push and pop
        for (int v = 10; v <= 13; v++) step(1, 1, v, 0, 0);
        step(1, 1, 14, 1, 0);
        step(1, 1, 15, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
        // interleaved traffic wrapping the pointers
        for (int i = 0; i < 10; i++) step(1, 1, 20 + i, (i % 3) != 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1);
        // clear_err loses to a new rejected push
        for (int v = 40; v <= 43; v++) step(1, 1, v, 0, 0);
        step(1, 1, 44, 0, 1);
        step(1, 0, 0, 0, 1);
        // reset mid-burst discards contents
        step(1, 0, 0, 1, 0);
        step(0, 1, 50, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 60, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("exp0_drained", 32'(exp0.size()), 32'h0);
        chk("exp1_drained", 32'(exp1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
